// File: rtl/reu_pkg.sv
// Shared definitions for the REU DMA transfer sequencer: sequencer states,
// transfer-type codes and the per-byte phase-count helper.
package reu_pkg;

  // Sequencer states; the four bus phases are consecutive so a byte can step
  // through them by incrementing the encoding.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_REQ  = 3'd2,
    ST_PH0  = 3'd3,
    ST_PH1  = 3'd4,
    ST_PH2  = 3'd5,
    ST_PH3  = 3'd6,
    ST_DONE = 3'd7
  } state_t;

  localparam logic [1:0] XFER_STASH  = 2'd0;
  localparam logic [1:0] XFER_FETCH  = 2'd1;
  localparam logic [1:0] XFER_SWAP   = 2'd2;
  localparam logic [1:0] XFER_VERIFY = 2'd3;

  // Number of bus phases needed to move one byte for a given transfer type.
  function automatic logic [2:0] phase_count(input logic [1:0] xfer_type);
    return (xfer_type == XFER_SWAP) ? 3'd4 : 3'd2;
  endfunction

  // Position of a bus-phase state within its byte (0 for non-phase states).
  function automatic logic [2:0] phase_index(input state_t st);
    case (st)
      ST_PH1:  return 3'd1;
      ST_PH2:  return 3'd2;
      ST_PH3:  return 3'd3;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/reu_dma_seq.sv
// REU DMA transfer sequencer. Takes the command state from the register
// block, owns the C64 bus and REU RAM strobes during a block transfer and
// reports per-byte steps and end/fault events back to the register block.
// Outputs are a decode of the registered state (plus the live BA and RAM
// compare), so each strobe lines up with the phase in which it is needed.
module reu_dma_seq
  import reu_pkg::*;
(
  input  logic       PHI2,
  input  logic       Reset,
  input  logic       Execute,
  input  logic       FF00Decode,
  input  logic [1:0] XferType,
  input  logic       Length1,
  input  logic       FF00Write,
  input  logic       BA,
  input  logic [7:0] CDin,
  input  logic [7:0] RAMDin,
  output logic       DMAOut,
  output logic       CRW,
  output logic       CDOE,
  output logic [7:0] CDout,
  output logic       RAMOE,
  output logic       RAMWE,
  output logic [7:0] RAMDout,
  output logic       NextCA,
  output logic       NextREUA,
  output logic       XferEnd,
  output logic       VerifyErr,
  output logic       Busy
);

  state_t     state_r;
  state_t     state_s;
  logic [7:0] d0_r;
  logic [7:0] d0_s;
  logic [7:0] d1_r;
  logic [7:0] d1_s;
  logic [2:0] phase_s;
  logic       last_s;
  logic       mismatch_s;

  // Locate the current bus phase and whether it finishes the byte.
  always_comb begin
    phase_s = phase_index(state_r);
    last_s  = (phase_s == (phase_count(XferType) - 3'd1));
  end

  // Next-state, latch loads and bus/RAM strobes for the current state.
  always_comb begin
    state_s    = state_r;
    d0_s       = d0_r;
    d1_s       = d1_r;
    mismatch_s = 1'b0;
    DMAOut     = 1'b0;
    CRW        = 1'b1;
    CDOE       = 1'b0;
    CDout      = 8'h00;
    RAMOE      = 1'b0;
    RAMWE      = 1'b0;
    RAMDout    = 8'h00;
    NextCA     = 1'b0;
    NextREUA   = 1'b0;
    XferEnd    = 1'b0;
    VerifyErr  = 1'b0;
    Busy       = (state_r != ST_IDLE);

    case (state_r)
      ST_IDLE: begin
        if (Execute) begin
          state_s = FF00Decode ? ST_ARM : ST_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_ARM: begin
        if (FF00Write) begin
          state_s = ST_REQ;
        end else begin
          state_s = ST_ARM;
        end
      end

      ST_REQ: begin
        DMAOut = 1'b1;
        if (BA) begin
          state_s = ST_PH0;
        end else begin
          state_s = ST_REQ;
        end
      end

      ST_PH0, ST_PH1, ST_PH2, ST_PH3: begin
        DMAOut = 1'b1;
        if (BA) begin
          case ({XferType, phase_s[1:0]})
            {XFER_STASH, 2'd0}:  d0_s = CDin;
            {XFER_STASH, 2'd1}: begin
              RAMWE   = 1'b1;
              RAMDout = d0_r;
            end
            {XFER_FETCH, 2'd0}: begin
              RAMOE = 1'b1;
              d0_s  = RAMDin;
            end
            {XFER_FETCH, 2'd1}: begin
              CRW   = 1'b0;
              CDOE  = 1'b1;
              CDout = d0_r;
            end
            {XFER_VERIFY, 2'd0}: d0_s = CDin;
            {XFER_VERIFY, 2'd1}: begin
              RAMOE      = 1'b1;
              mismatch_s = (RAMDin != d0_r);
            end
            {XFER_SWAP, 2'd0}:   d0_s = CDin;
            {XFER_SWAP, 2'd1}: begin
              RAMOE = 1'b1;
              d1_s  = RAMDin;
            end
            {XFER_SWAP, 2'd2}: begin
              RAMWE   = 1'b1;
              RAMDout = d0_r;
            end
            {XFER_SWAP, 2'd3}: begin
              CRW   = 1'b0;
              CDOE  = 1'b1;
              CDout = d1_r;
            end
            default: d0_s = d0_r;
          endcase

          if (last_s) begin
            if (mismatch_s) begin
              VerifyErr = 1'b1;
              state_s   = ST_DONE;
            end else begin
              NextCA   = 1'b1;
              NextREUA = 1'b1;
              if (Length1) begin
                XferEnd = 1'b1;
                state_s = ST_DONE;
              end else begin
                state_s = ST_PH0;
              end
            end
          end else begin
            state_s = state_t'(state_r + 3'd1);
          end
        end else begin
          // bus stolen: hold phase and latches, keep /DMA asserted
          state_s = state_r;
        end
      end

      ST_DONE: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and data latches advance on the falling edge of PHI2.
  always_ff @(negedge PHI2) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      d0_r    <= 8'h00;
      d1_r    <= 8'h00;
    end else begin
      state_r <= state_s;
      d0_r    <= d0_s;
      d1_r    <= d1_s;
    end
  end

endmodule

// File: tb/tb_reu_dma_seq.sv
// Self-checking bench for reu_dma_seq: a table of transfers plus random
// transfers, every cycle compared against a transfer-level model built from
// per-type operation lists, and hand sequences for stall and reset cases.
module tb_reu_dma_seq;

  logic       PHI2, Reset, Execute, FF00Decode, Length1, FF00Write, BA;
  logic [1:0] XferType;
  logic [7:0] CDin, RAMDin;
  logic       DMAOut, CRW, CDOE, RAMOE, RAMWE, NextCA, NextREUA, XferEnd, VerifyErr, Busy;
  logic [7:0] CDout, RAMDout;

  reu_dma_seq dut (
    .PHI2(PHI2), .Reset(Reset), .Execute(Execute), .FF00Decode(FF00Decode),
    .XferType(XferType), .Length1(Length1), .FF00Write(FF00Write), .BA(BA),
    .CDin(CDin), .RAMDin(RAMDin), .DMAOut(DMAOut), .CRW(CRW), .CDOE(CDOE),
    .CDout(CDout), .RAMOE(RAMOE), .RAMWE(RAMWE), .RAMDout(RAMDout),
    .NextCA(NextCA), .NextREUA(NextREUA), .XferEnd(XferEnd),
    .VerifyErr(VerifyErr), .Busy(Busy)
  );

  initial PHI2 = 1'b1;
  always #5 PHI2 = ~PHI2;

  typedef struct packed {
    logic dma; logic crw; logic cdoe; logic [7:0] cdout; logic ramoe; logic ramwe;
    logic [7:0] ramdout; logic nca; logic nra; logic xend; logic verr; logic busy;
  } outv_t;

  // byte-level operations: C64 read, RAM read, RAM write, C64 write, RAM compare
  localparam int K_CRD = 0, K_RRD = 1, K_RWR = 2, K_CWR = 3, K_RCMP = 4;
  typedef struct { int kind; int idx; } op_t;
  typedef enum { M_IDLE, M_ARM, M_REQ, M_BUS, M_DONE } mph_e;

  typedef struct {
    string name; int xfer; int nbytes; bit ff00; int arm_wait; int stall; int mis;
    int exp_next; int exp_xend; int exp_verr;
  } vec_t;

  mph_e       m_ph;
  int         m_op, m_left, m_nbytes, m_mis;
  logic [1:0] m_type;
  logic       m_ff00, m_exec;
  logic [7:0] m_lat [2];
  int         errors, checks;
  bit         data_fixed;
  logic [7:0] fix_cd [8];
  logic [7:0] fix_ram [8];
  logic [7:0] wq[$];
  logic [7:0] cq[$];
  int         obs_next, obs_xend, obs_verr;
  outv_t      last_a;

  function automatic op_t mk(input int k, input int x);
    op_t o;
    o.kind = k;
    o.idx  = x;
    return o;
  endfunction

  // what each byte of each transfer type does, phase by phase
  function automatic op_t op_of(input logic [1:0] t, input int i);
    op_t o;
    case (t)
      2'd0:    o = (i == 0) ? mk(K_CRD, 0) : mk(K_RWR, 0);
      2'd1:    o = (i == 0) ? mk(K_RRD, 0) : mk(K_CWR, 0);
      2'd3:    o = (i == 0) ? mk(K_CRD, 0) : mk(K_RCMP, 0);
      default: begin
        case (i)
          0:       o = mk(K_CRD, 0);
          1:       o = mk(K_RRD, 1);
          2:       o = mk(K_RWR, 0);
          default: o = mk(K_CWR, 1);
        endcase
      end
    endcase
    return o;
  endfunction

  function automatic int n_ops(input logic [1:0] t);
    return (t == 2'd2) ? 4 : 2;
  endfunction

  function automatic int cur_byte();
    int b;
    b = m_nbytes - m_left;
    if (b < 0) b = 0;
    if (b > 7) b = 7;
    return b;
  endfunction

  function automatic outv_t model_out();
    outv_t e;
    op_t   o;
    e      = '0;
    e.crw  = 1'b1;
    e.busy = (m_ph != M_IDLE);
    e.dma  = (m_ph == M_REQ) || (m_ph == M_BUS);
    if (m_ph == M_BUS && BA) begin
      o = op_of(m_type, m_op);
      case (o.kind)
        K_RRD, K_RCMP: e.ramoe = 1'b1;
        K_RWR: begin e.ramwe = 1'b1; e.ramdout = m_lat[o.idx]; end
        K_CWR: begin e.crw = 1'b0; e.cdoe = 1'b1; e.cdout = m_lat[o.idx]; end
        default: ;
      endcase
      if (m_op == n_ops(m_type) - 1) begin
        if (o.kind == K_RCMP && RAMDin != m_lat[0]) begin
          e.verr = 1'b1;
        end else begin
          e.nca  = 1'b1;
          e.nra  = 1'b1;
          e.xend = (m_left == 1);
        end
      end
    end
    return e;
  endfunction

  function automatic void model_advance(input outv_t e);
    op_t o;
    if (Reset) begin
      m_ph = M_IDLE; m_exec = 1'b0; m_lat[0] = 8'h00; m_lat[1] = 8'h00;
      return;
    end
    case (m_ph)
      M_IDLE: if (Execute) m_ph = m_ff00 ? M_ARM : M_REQ;
      M_ARM:  if (FF00Write) m_ph = M_REQ;
      M_REQ:  if (BA) begin m_ph = M_BUS; m_op = 0; end
      M_BUS: begin
        if (BA) begin
          o = op_of(m_type, m_op);
          if (o.kind == K_CRD) m_lat[o.idx] = CDin;
          else if (o.kind == K_RRD) m_lat[o.idx] = RAMDin;
          if (m_op == n_ops(m_type) - 1) begin
            if (e.verr || m_left == 1) begin m_ph = M_DONE; m_exec = 1'b0; end
            else begin m_left--; m_op = 0; end
          end else begin
            m_op++;
          end
        end
      end
      default: m_ph = M_IDLE;
    endcase
  endfunction

  task automatic check_val(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // drive one cycle, compare at the rising edge, advance the model at the falling edge
  task automatic step(input logic ba_i, input logic ffw_i, input logic rst_i, input string nm);
    outv_t e, a;
    op_t   o;
    logic  last_op;
    int    b;
    b         = cur_byte();
    last_op   = (m_ph == M_BUS) && (m_op == n_ops(m_type) - 1);
    Reset     = rst_i;
    BA        = ba_i;
    FF00Write = ffw_i;
    XferType  = m_type;
    FF00Decode = m_ff00;
    Execute   = (m_ph == M_BUS) ? 1'($urandom_range(1)) : m_exec;
    Length1   = (m_ph == M_BUS && !last_op) ? 1'($urandom_range(1)) : (m_left == 1);
    if (data_fixed) begin
      CDin   = fix_cd[b];
      RAMDin = fix_ram[b];
    end else begin
      CDin   = 8'($urandom);
      RAMDin = 8'($urandom);
      if (m_ph == M_BUS) begin
        o = op_of(m_type, m_op);
        if (o.kind == K_RCMP) RAMDin = (b == m_mis) ? (m_lat[0] ^ 8'h5C) : m_lat[0];
      end
    end
    @(posedge PHI2);
    e = model_out();
    a = {DMAOut, CRW, CDOE, CDout, RAMOE, RAMWE, RAMDout, NextCA, NextREUA, XferEnd, VerifyErr, Busy};
    last_a = a;
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: outputs got %h want %h (model phase %0d op %0d)", nm, a, e, m_ph, m_op);
    end
    if (a.nca)   obs_next++;
    if (a.xend)  obs_xend++;
    if (a.verr)  obs_verr++;
    if (a.ramwe) wq.push_back(a.ramdout);
    if (a.cdoe)  cq.push_back(a.cdout);
    @(negedge PHI2);
    model_advance(e);
    #1;
  endtask

  task automatic start_xfer(input int t, input int n, input bit ff, input int mis);
    m_type = 2'(t); m_nbytes = n; m_left = n; m_ff00 = ff; m_mis = mis; m_exec = 1'b1;
    wq.delete(); cq.delete();
    obs_next = 0; obs_xend = 0; obs_verr = 0;
  endtask

  task automatic run_xfer(input vec_t v, input bit chk);
    int   cyc, aw;
    logic ba, ffw;
    start_xfer(v.xfer, v.nbytes, v.ff00, v.mis);
    cyc = 0;
    aw  = 0;
    do begin
      ba  = (m_ph == M_REQ || m_ph == M_BUS) ? ($urandom_range(99) >= v.stall) : 1'($urandom_range(1));
      ffw = (m_ph == M_ARM) ? (aw >= v.arm_wait) : 1'($urandom_range(1));
      if (m_ph == M_ARM) aw++;
      step(ba, ffw, 1'b0, v.name);
      cyc++;
    end while (m_ph != M_IDLE && cyc < 3000);
    if (m_ph != M_IDLE) begin
      checks++; errors++;
      $display("FAIL %s timeout: still busy after %0d cycles, want idle", v.name, cyc);
      m_ph = M_IDLE;
    end
    if (chk) begin
      check_val({v.name, " next pulses"}, obs_next, v.exp_next);
      check_val({v.name, " xferend pulses"}, obs_xend, v.exp_xend);
      check_val({v.name, " verifyerr pulses"}, obs_verr, v.exp_verr);
    end
  endtask

  vec_t vecs [9];
  vec_t rv;

  initial begin
    int cyc;
    errors = 0; checks = 0; data_fixed = 1'b0;
    m_ph = M_IDLE; m_op = 0; m_left = 0; m_nbytes = 0; m_mis = -1;
    m_type = 2'd0; m_ff00 = 1'b0; m_exec = 1'b0; m_lat[0] = 8'h00; m_lat[1] = 8'h00;
    for (int i = 0; i < 8; i++) begin fix_cd[i] = 8'h00; fix_ram[i] = 8'h00; end

    //         name         type n ff00 aw stall mis  next xend verr
    vecs[0] = '{"stash2",    0, 2, 1'b0, 0,  0, -1,  2, 1, 0};
    vecs[1] = '{"fetch3ff",  1, 3, 1'b1, 3, 30, -1,  3, 1, 0};
    vecs[2] = '{"swap2",     2, 2, 1'b0, 0, 25, -1,  2, 1, 0};
    vecs[3] = '{"verify3ok", 3, 3, 1'b0, 0,  0, -1,  3, 1, 0};
    vecs[4] = '{"verifymis", 3, 4, 1'b1, 2, 20,  2,  2, 0, 1};
    vecs[5] = '{"verifylast",3, 1, 1'b0, 0,  0,  0,  0, 0, 1};
    vecs[6] = '{"stash1st",  0, 1, 1'b0, 0, 40, -1,  1, 1, 0};
    vecs[7] = '{"arm10swap", 2, 3, 1'b1,10, 10, -1,  3, 1, 0};
    vecs[8] = '{"fetch5st",  1, 5, 1'b0, 0, 50, -1,  5, 1, 0};

    Reset = 1'b1; Execute = 1'b0; FF00Decode = 1'b0; XferType = 2'd0; Length1 = 1'b0;
    FF00Write = 1'b0; BA = 1'b1; CDin = 8'h00; RAMDin = 8'h00;
    repeat (2) @(negedge PHI2);
    @(posedge PHI2);
    check_val("reset outputs",
              {DMAOut, CRW, CDOE, CDout, RAMOE, RAMWE, RAMDout, NextCA, NextREUA, XferEnd, VerifyErr, Busy},
              {1'b0, 1'b1, 24'h0});
    @(negedge PHI2);
    #1;
    Reset = 1'b0;

    for (int i = 0; i < 9; i++) run_xfer(vecs[i], 1'b1);

    // stash of 0x5A then 0xA5 lands in RAM in order
    data_fixed = 1'b1;
    fix_cd[0] = 8'h5A; fix_cd[1] = 8'hA5;
    run_xfer('{"tp stash", 0, 2, 1'b0, 0, 0, -1, 2, 1, 0}, 1'b1);
    check_val("tp stash writes", wq.size(), 2);
    if (wq.size() == 2) begin
      check_val("tp stash byte0", wq[0], 8'h5A);
      check_val("tp stash byte1", wq[1], 8'hA5);
    end

    // one-byte swap exchanges 0x11 and 0x22
    fix_cd[0] = 8'h11; fix_ram[0] = 8'h22;
    run_xfer('{"tp swap", 2, 1, 1'b0, 0, 0, -1, 1, 1, 0}, 1'b1);
    check_val("tp swap ram count", wq.size(), 1);
    check_val("tp swap c64 count", cq.size(), 1);
    if (wq.size() == 1) check_val("tp swap ram data", wq[0], 8'h11);
    if (cq.size() == 1) check_val("tp swap c64 data", cq[0], 8'h22);

    // verify of 0x34 against RAM 0x33 faults on the first byte
    fix_cd[0] = 8'h34; fix_ram[0] = 8'h33;
    run_xfer('{"tp verify", 3, 2, 1'b0, 0, 0, -1, 0, 0, 1}, 1'b1);

    // fetch with the bus stolen for three cycles in the C64-write phase
    fix_ram[0] = 8'h77;
    start_xfer(1, 1, 1'b0, -1);
    repeat (3) step(1'b1, 1'b0, 1'b0, "stall lead");
    fix_ram[0] = 8'h99;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, "stall hold");
      check_val("stall strobes quiet", {last_a.dma, last_a.cdoe, last_a.nca, last_a.nra}, 4'b1000);
    end
    step(1'b1, 1'b0, 1'b0, "stall resume");
    check_val("stall resume data", {last_a.cdoe, last_a.nca, last_a.cdout}, {2'b11, 8'h77});
    step(1'b1, 1'b0, 1'b0, "stall done");
    step(1'b1, 1'b0, 1'b0, "stall idle");

    // reset in the middle of a swap
    data_fixed = 1'b0;
    start_xfer(2, 2, 1'b0, -1);
    cyc = 0;
    while (!(m_ph == M_BUS && m_op == 2) && cyc < 20) begin
      step(1'b1, 1'b0, 1'b0, "swap lead");
      cyc++;
    end
    check_val("swap reached ph2", (m_ph == M_BUS && m_op == 2) ? 1 : 0, 1);
    step(1'b1, 1'b0, 1'b1, "swap reset edge");
    step(1'b1, 1'b0, 1'b0, "after reset");
    check_val("after reset busy/dma/ramwe/crw",
              {last_a.busy, last_a.dma, last_a.ramwe, last_a.crw}, 4'b0001);

    // random transfers
    for (int i = 0; i < 25; i++) begin
      rv.name     = "random";
      rv.xfer     = $urandom_range(3);
      rv.nbytes   = $urandom_range(6, 1);
      rv.ff00     = 1'($urandom_range(1));
      rv.arm_wait = $urandom_range(4);
      rv.stall    = $urandom_range(50);
      rv.mis      = $urandom_range(rv.nbytes) - 1;
      rv.exp_next = 0; rv.exp_xend = 0; rv.exp_verr = 0;
      run_xfer(rv, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
